// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: widths, state encoding, helpers.
package program_sequencer_pkg;

   localparam int unsigned DEF_INSTR_W    = 26;
   localparam int unsigned DEF_ADDR_W     = 16;
   localparam int unsigned DEF_PROG_DEPTH = 64;
   localparam int unsigned CNT_W          = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EXEC  = 3'd3,
      ST_DONE  = 3'd4
   } seqState_t;

   // Saturating increment for the issue counter.
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/program_sequencer.sv
// Program sequencer for the control_matrix soft CPU: loads a program image into
// external synchronous memory, then fetches and issues one instruction per IP.
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int unsigned INSTR_W    = DEF_INSTR_W,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned PROG_DEPTH = DEF_PROG_DEPTH
) (
   input  logic               clock,
   input  logic               resetN,
   input  logic               loadValid,
   output logic               loadReady,
   input  logic [ADDR_W-1:0]  loadAddr,
   input  logic [INSTR_W-1:0] loadData,
   input  logic [ADDR_W-1:0]  progLength,
   input  logic               run,
   input  logic               step,
   input  logic               haltReq,
   input  logic [ADDR_W-1:0]  instructionPointer,
   output logic [INSTR_W-1:0] instruction,
   output logic               cpuEnable,
   output logic [ADDR_W-1:0]  memAddr,
   output logic               memReadEn,
   output logic               memWriteEn,
   output logic [INSTR_W-1:0] memWdata,
   input  logic [INSTR_W-1:0] memRdata,
   output logic               busy,
   output logic               done,
   output logic               loadErr,
   output logic [CNT_W-1:0]   instrCount
);

   seqState_t         state;
   seqState_t         stateNext;

   logic [ADDR_W-1:0] progLen;
   logic              stepMode;
   logic              haltSeen;

   logic              startSeq;
   logic              loadErrSet;
   logic              doneSet;
   logic              captureInstr;
   logic              issueInstr;
   logic              loadAddrOk;

   assign loadAddrOk = (loadAddr < ADDR_W'(PROG_DEPTH));

   // State register; reset returns to IDLE immediately.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state decode plus memory, CPU strobe and status decodes.
   always_comb begin
      stateNext    = state;
      loadReady    = 1'b0;
      busy         = 1'b0;
      cpuEnable    = 1'b0;
      memAddr      = '0;
      memReadEn    = 1'b0;
      memWriteEn   = 1'b0;
      memWdata     = '0;
      startSeq     = 1'b0;
      loadErrSet   = 1'b0;
      doneSet      = 1'b0;
      captureInstr = 1'b0;
      issueInstr   = 1'b0;

      unique case (state)
         ST_IDLE: begin
            loadReady = 1'b1;
            // Writes go straight through to memory; out-of-range words are dropped.
            if (loadValid && resetN) begin
               if (loadAddrOk) begin
                  memWriteEn = 1'b1;
                  memAddr    = loadAddr;
                  memWdata   = loadData;
               end else begin
                  loadErrSet = 1'b1;
               end
            end
            if (run || step) begin
               startSeq  = 1'b1;
               stateNext = ST_FETCH;
            end
         end

         ST_FETCH: begin
            busy = 1'b1;
            if (instructionPointer >= progLen) begin
               doneSet   = 1'b1;
               stateNext = ST_DONE;
            end else begin
               memAddr   = instructionPointer;
               memReadEn = 1'b1;
               stateNext = ST_WAIT;
            end
         end

         ST_WAIT: begin
            busy         = 1'b1;
            captureInstr = 1'b1;
            stateNext    = ST_EXEC;
         end

         ST_EXEC: begin
            busy       = 1'b1;
            cpuEnable  = 1'b1;
            issueInstr = 1'b1;
            if (haltSeen || haltReq || stepMode) begin
               stateNext = ST_IDLE;
            end else begin
               stateNext = ST_FETCH;
            end
         end

         ST_DONE: begin
            if (!run && !step) begin
               stateNext = ST_IDLE;
            end
         end

         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

   // Sequence context, fetched instruction and status flags.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         progLen     <= '0;
         stepMode    <= 1'b0;
         haltSeen    <= 1'b0;
         instruction <= '0;
         instrCount  <= '0;
         done        <= 1'b0;
         loadErr     <= 1'b0;
      end else begin
         if (startSeq) begin
            progLen    <= progLength;
            stepMode   <= !run;
            haltSeen   <= 1'b0;
            instrCount <= '0;
            done       <= 1'b0;
            loadErr    <= 1'b0;
         end
         if (loadErrSet) begin
            loadErr <= 1'b1;
         end
         if (doneSet) begin
            done <= 1'b1;
         end
         if (captureInstr) begin
            instruction <= memRdata;
         end
         if (issueInstr) begin
            instrCount <= satInc(instrCount);
         end
         if (busy && haltReq) begin
            haltSeen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer with a sync memory and a simple CPU model.
module tb_program_sequencer;

   logic        clock;
   logic        resetN;
   logic        loadValid;
   logic        loadReady;
   logic [15:0] loadAddr;
   logic [25:0] loadData;
   logic [15:0] progLength;
   logic        run;
   logic        step;
   logic        haltReq;
   logic [15:0] instructionPointer;
   logic [25:0] instruction;
   logic        cpuEnable;
   logic [15:0] memAddr;
   logic        memReadEn;
   logic        memWriteEn;
   logic [25:0] memWdata;
   logic [25:0] memRdata;
   logic        busy;
   logic        done;
   logic        loadErr;
   logic [15:0] instrCount;

   int          assertCount = 0;
   int          failCount   = 0;

   logic [25:0] ram    [64];
   logic [25:0] refMem [64];
   bit          errModel;

   program_sequencer dut (
      .clock              (clock),
      .resetN             (resetN),
      .loadValid          (loadValid),
      .loadReady          (loadReady),
      .loadAddr           (loadAddr),
      .loadData           (loadData),
      .progLength         (progLength),
      .run                (run),
      .step               (step),
      .haltReq            (haltReq),
      .instructionPointer (instructionPointer),
      .instruction        (instruction),
      .cpuEnable          (cpuEnable),
      .memAddr            (memAddr),
      .memReadEn          (memReadEn),
      .memWriteEn         (memWriteEn),
      .memWdata           (memWdata),
      .memRdata           (memRdata),
      .busy               (busy),
      .done               (done),
      .loadErr            (loadErr),
      .instrCount         (instrCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // External synchronous program memory, one-cycle read latency.
   always @(posedge clock) begin
      if (memWriteEn) ram[memAddr[5:0]] <= memWdata;
      if (memReadEn)  memRdata <= ram[memAddr[5:0]];
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one load word in IDLE and check the write strobe and error flag.
   task automatic loadWord(input int addr, input logic [25:0] data);
      bit ok;
      ok = (addr < 64);
      checkVal("loadReady", 32'(loadReady), 1);
      loadValid = 1'b1;
      loadAddr  = 16'(addr);
      loadData  = data;
      #1;
      checkVal("wrEn", 32'(memWriteEn), 32'(ok));
      if (ok) begin
         checkVal("wrAddr", 32'(memAddr), 32'(addr));
         checkVal("wrData", 32'(memWdata), 32'(data));
      end
      tick();
      loadValid = 1'b0;
      if (ok) refMem[addr] = data;
      else    errModel = 1'b1;
      checkVal("loadErr", 32'(loadErr), 32'(errModel));
   endtask

   // mode: 0 run, 1 step, 2 run+step together. haltIp < 0 means no halt.
   task automatic runSeq(input int startIp, input int len, input int mode, input int haltIp);
      int expIssues[$];
      int ip, cyc, lastFetch, lastIssue, nIssued, budget;
      bit fin, expDone, haltFire, haltClear, stepMode;
      stepMode = (mode == 1);
      expDone  = 1'b1;
      if (stepMode) begin
         if (startIp < len) begin
            expIssues.push_back(startIp);
            expDone = 1'b0;
         end
      end else begin
         for (int k = startIp; k < len; k++) begin
            expIssues.push_back(k);
            if (k == haltIp) begin
               expDone = 1'b0;
               break;
            end
         end
      end

      ip = startIp;
      instructionPointer = 16'(ip);
      progLength = 16'(len);
      run  = (mode != 1);
      step = (mode != 0);
      tick();
      step = 1'b0;
      errModel = 1'b0;
      checkVal("startBusy", 32'(busy), 1);
      checkVal("errClr", 32'(loadErr), 0);
      checkVal("doneClr", 32'(done), 0);
      checkVal("cntClr", 32'(instrCount), 0);

      cyc = 0; lastFetch = -100; lastIssue = -1; nIssued = 0;
      fin = 1'b0; haltFire = 1'b0; haltClear = 1'b0;
      budget = 3 * len + 12;
      while (!fin && cyc < budget) begin
         if (haltFire) begin
            haltReq = 1'b1;
            run = 1'b0;
            haltFire = 1'b0;
            haltClear = 1'b1;
         end else if (haltClear) begin
            haltReq = 1'b0;
            haltClear = 1'b0;
         end
         if (memReadEn) begin
            checkVal("fetchAddr", 32'(memAddr), 32'(ip));
            lastFetch = cyc;
            if (ip == haltIp) haltFire = 1'b1;
         end
         if (cpuEnable) begin
            if (nIssued < expIssues.size())
               checkVal("instr", 32'(instruction), 32'(refMem[expIssues[nIssued]]));
            checkVal("latency", 32'(cyc - lastFetch), 2);
            if (lastIssue >= 0) checkVal("rate", 32'(cyc - lastIssue), 3);
            lastIssue = cyc;
            nIssued++;
            ip++;
            instructionPointer = 16'(ip);
         end
         if (done) checkVal("doneBusy", 32'(busy), 0);
         if (done || loadReady) begin
            fin = 1'b1;
         end else begin
            tick();
            cyc++;
         end
      end

      checkVal("finished", 32'(fin), 1);
      checkVal("issues", 32'(nIssued), 32'(expIssues.size()));
      checkVal("count", 32'(instrCount), 32'(expIssues.size()));
      checkVal("done", 32'(done), 32'(expDone));
      if (expIssues.size() == 0) checkVal("emptyLatency", 32'(cyc), 1);
      run = 1'b0; step = 1'b0; haltReq = 1'b0;
      tick();
      tick();
      checkVal("idleReady", 32'(loadReady), 1);
      checkVal("idleBusy", 32'(busy), 0);
      checkVal("doneHeld", 32'(done), 32'(expDone));
      if (expIssues.size() > 0)
         checkVal("instrHeld", 32'(instruction), 32'(refMem[expIssues[expIssues.size()-1]]));
   endtask

   initial begin
      int len, startIp, mode, haltIp;
      resetN = 1'b0; loadValid = 1'b0; loadAddr = '0; loadData = '0;
      progLength = '0; run = 1'b0; step = 1'b0; haltReq = 1'b0;
      instructionPointer = '0; errModel = 1'b0;
      tick(); tick();
      checkVal("rstReady", 32'(loadReady), 1);
      checkVal("rstBusy", 32'(busy), 0);
      checkVal("rstCpuEn", 32'(cpuEnable), 0);
      checkVal("rstInstr", 32'(instruction), 0);
      checkVal("rstCount", 32'(instrCount), 0);
      checkVal("rstDone", 32'(done), 0);
      resetN = 1'b1;
      tick();

      // Directed: 7-word program, full run, step, halt, run+step together.
      for (int a = 0; a < 7; a++) loadWord(a, 26'($urandom));
      runSeq(0, 7, 0, -1);
      runSeq(3, 7, 1, -1);
      runSeq(0, 7, 0, 2);
      runSeq(0, 7, 2, -1);

      // Out-of-range loads set a sticky error that the next start clears.
      loadWord(64, 26'($urandom));
      loadWord(5, 26'($urandom));
      loadWord(int'($urandom_range(65, 65535)), 26'($urandom));
      runSeq(0, 0, 0, -1);

      // Reset during WAIT.
      progLength = 16'd7; instructionPointer = '0; run = 1'b1;
      tick();
      for (int i = 0; i < 10 && !memReadEn; i++) tick();
      checkVal("rstFetchSeen", 32'(memReadEn), 1);
      tick();
      #2 resetN = 1'b0;
      #1;
      checkVal("midRstReady", 32'(loadReady), 1);
      checkVal("midRstBusy", 32'(busy), 0);
      checkVal("midRstCpuEn", 32'(cpuEnable), 0);
      checkVal("midRstRead", 32'(memReadEn), 0);
      checkVal("midRstAddr", 32'(memAddr), 0);
      checkVal("midRstInstr", 32'(instruction), 0);
      checkVal("midRstCount", 32'(instrCount), 0);
      checkVal("midRstDone", 32'(done), 0);
      checkVal("midRstErr", 32'(loadErr), 0);
      run = 1'b0;
      tick();
      resetN = 1'b1;
      errModel = 1'b0;
      tick();
      runSeq(0, 7, 0, -1);

      // Randomized: fill the whole memory, then random runs/steps/halts.
      for (int a = 0; a < 64; a++) begin
         loadWord(a, 26'($urandom));
         if ($urandom_range(0, 7) == 0) loadWord(int'($urandom_range(64, 65535)), 26'($urandom));
      end
      for (int r = 0; r < 20; r++) begin
         len = int'($urandom_range(0, 64));
         startIp = int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(0, len + 2))
                                                    : int'($urandom_range(0, len / 2));
         mode = int'($urandom_range(0, 2));
         haltIp = -1;
         if (mode != 1 && startIp < len && $urandom_range(0, 1) == 1)
            haltIp = int'($urandom_range(startIp, len - 1));
         runSeq(startIp, len, mode, haltIp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
